// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants and fetch-state type
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FULL  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, single-outstanding imem request, held instruction
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] target;
    logic              unused_tgt_bits;

    assign target          = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_tgt_bits = ^branch_target[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        if (branch_taken && state_q != ST_IDLE) begin
            // Redirect beats everything; an accepted or pending request becomes stale.
            pc_d    = target;
            valid_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = ST_FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_d = ST_WAIT;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + PC_STEP;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            state_d = ST_FETCH;
                            drop_d  = 1'b0;
                        end else begin
                            state_d = ST_FULL;
                            instr_d = imem_rdata;
                            valid_d = 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (instr_ready) begin
                        state_d = ST_FETCH;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        branch_taken;
    logic [31:0] branch_target;

    int checks = 0;
    int errors = 0;

    int          mem_lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic [31:0] req_log[$];
    logic [31:0] acc_pc[$];
    logic [5:0]  acc_op[$];

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    // Opcode chosen by address bits [3:2] so consecutive words differ.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [5:0] op;
        case (a[3:2])
            2'd0: op = OP_LW;
            2'd1: op = OP_ADDI;
            2'd2: op = OP_BEQ;
            default: op = OP_SW;
        endcase
        return {op, a[25:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: present memory response, note handshakes, advance, settle.
    task automatic tick();
        logic hs, rv, acc;
        logic [31:0] a;
        rv = pend && (cnt == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? word_at(paddr) : 32'hDEAD_BEEF;
        hs  = imem_req && imem_ready;
        a   = imem_addr;
        acc = instr_valid && instr_ready;
        if (acc) begin
            acc_pc.push_back(instr_pc);
            acc_op.push_back(opcode);
        end
        @(posedge clk);
        if (rv) pend = 1'b0;
        else if (pend) cnt--;
        if (hs) begin
            pend  = 1'b1;
            cnt   = mem_lat - 1;
            paddr = a;
            req_log.push_back(a);
        end
        #1;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b1; branch_taken = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_ipc", instr_pc, 32'd0);
        check("rst_addr", imem_addr, 32'h100);
        rst = 1'b0;
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h100);

        // Sequential stream, 1 instruction per 3 cycles
        req_log.delete(); acc_pc.delete(); acc_op.delete();
        repeat (9) tick();
        check("stream_n_acc", acc_pc.size(), 32'd3);
        check("stream_n_req", req_log.size(), 32'd3);
        if (req_log.size() == 3 && acc_pc.size() == 3) begin
            check("req0", req_log[0], 32'h100);
            check("req1", req_log[1], 32'h104);
            check("req2", req_log[2], 32'h108);
            check("ipc0", acc_pc[0], 32'h100);
            check("ipc1", acc_pc[1], 32'h104);
            check("ipc2", acc_pc[2], 32'h108);
            check("op0", {26'd0, acc_op[0]}, 32'b100011);
            check("op1", {26'd0, acc_op[1]}, 32'b001000);
            check("op2", {26'd0, acc_op[2]}, 32'b000100);
        end
        check("next_addr", imem_addr, 32'h10C);

        // Backpressure while FULL
        instr_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_instr", instr, 32'hAC00_010C);
            check("hold_opcode", {26'd0, opcode}, 32'b101011);
            check("hold_ipc", instr_pc, 32'h10C);
            check("hold_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        check("release_req", {31'd0, imem_req}, 32'd1);
        check("release_addr", imem_addr, 32'h110);
        check("release_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect in WAIT, stale response 3 cycles after the redirect
        mem_lat = 4;
        tick();
        branch_taken = 1'b1; branch_target = 32'h203;
        tick();
        branch_taken = 1'b0;
        check("wbr_valid", {31'd0, instr_valid}, 32'd0);
        check("wbr_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wbr_wait_valid", {31'd0, instr_valid}, 32'd0);
            check("wbr_wait_req", {31'd0, imem_req}, 32'd0);
        end
        tick();
        check("wbr_drop_valid", {31'd0, instr_valid}, 32'd0);
        check("wbr_tgt_req", {31'd0, imem_req}, 32'd1);
        check("wbr_tgt_addr", imem_addr, 32'h200);

        // Redirect in the same cycle as rvalid
        mem_lat = 1;
        tick();
        branch_taken = 1'b1; branch_target = 32'h300;
        tick();
        branch_taken = 1'b0;
        check("rvbr_valid", {31'd0, instr_valid}, 32'd0);
        check("rvbr_req", {31'd0, imem_req}, 32'd1);
        check("rvbr_addr", imem_addr, 32'h300);

        // Redirect while FULL with instr_ready high, target at PC wrap point
        tick(); tick();
        check("full_valid", {31'd0, instr_valid}, 32'd1);
        check("full_instr", instr, 32'h8C00_0300);
        check("full_ipc", instr_pc, 32'h300);
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        check("fbr_valid", {31'd0, instr_valid}, 32'd0);
        check("fbr_req", {31'd0, imem_req}, 32'd1);
        check("fbr_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        check("wrap_valid", {31'd0, instr_valid}, 32'd1);
        check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_opcode", {26'd0, opcode}, 32'b101011);
        tick();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_req", {31'd0, imem_req}, 32'd1);

        // Asynchronous reset in the middle of WAIT
        mem_lat = 4;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_opcode", {26'd0, opcode}, 32'd0);
        check("arst_ipc", instr_pc, 32'd0);
        check("arst_addr", imem_addr, 32'h100);
        pend = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_lat = 1;
        tick();
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h100);
        tick(); tick();
        check("restart_valid", {31'd0, instr_valid}, 32'd1);
        check("restart_instr", instr, 32'h8C00_0100);
        check("restart_ipc", instr_pc, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
